// File: rtl/envelope.sv
// ADSR envelope: scales an offset-binary sample about midscale by a gate/tick-driven level.
// wave_out is registered 1 clk after wave_in; there is no handshake and the level moves only on sample_tick.
module envelope #(
   parameter int m = 12,
   parameter int r = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sample_tick,
   input  logic         gate,
   input  logic [m-1:0] wave_in,
   input  logic [r-1:0] attack_rate,
   input  logic [r-1:0] decay_rate,
   input  logic [m-1:0] sustain_level,
   input  logic [r-1:0] release_rate,
   output logic [m-1:0] wave_out,
   output logic [m-1:0] env_level,
   output logic [2:0]   env_state,
   output logic         active
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_t;

   localparam logic [m:0]   LVL_MAX  = {1'b0, {m{1'b1}}};
   localparam logic [m-1:0] MIDSCALE = {1'b1, {(m-1){1'b0}}};

   state_t       state, state_nxt;
   logic [m-1:0] level, level_nxt;
   logic [m:0]   attack_sum, decay_floor;

   // Gate transitions take priority over a coincident tick and leave the level untouched.
   always_comb begin
      attack_sum  = {1'b0, level} + (m+1)'(attack_rate);
      decay_floor = {1'b0, sustain_level} + (m+1)'(decay_rate);
      state_nxt   = state;
      level_nxt   = level;
      case (state)
         IDLE: begin
            if (gate) state_nxt = ATTACK;
         end
         ATTACK: begin
            if (!gate) begin
               state_nxt = RELEASE;
            end else if (sample_tick) begin
               if (attack_sum >= LVL_MAX) begin
                  level_nxt = LVL_MAX[m-1:0];
                  state_nxt = DECAY;
               end else begin
                  level_nxt = attack_sum[m-1:0];
               end
            end
         end
         DECAY: begin
            if (!gate) begin
               state_nxt = RELEASE;
            end else if (sample_tick) begin
               if ({1'b0, level} <= decay_floor) begin
                  level_nxt = sustain_level;
                  state_nxt = SUSTAIN;
               end else begin
                  level_nxt = level - m'(decay_rate);
               end
            end
         end
         SUSTAIN: begin
            if (!gate) state_nxt = RELEASE;
            else if (sample_tick) level_nxt = sustain_level;
         end
         RELEASE: begin
            if (gate) begin
               state_nxt = ATTACK;
            end else if (sample_tick) begin
               if (level <= m'(release_rate)) begin
                  level_nxt = '0;
                  state_nxt = IDLE;
               end else begin
                  level_nxt = level - m'(release_rate);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            level_nxt = '0;
         end
      endcase
   end

   logic signed [m-1:0] samp_s;
   logic signed [m:0]   level_s;
   logic signed [2*m:0] prod;
   logic                unused_prod;

   // Level is zero-extended so a full-scale level never flips the product sign.
   always_comb begin
      samp_s  = {~wave_in[m-1], wave_in[m-2:0]};
      level_s = {1'b0, level};
      prod    = (2*m+1)'(samp_s) * (2*m+1)'(level_s);
   end

   assign unused_prod = ^{prod[2*m], prod[m-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         level    <= '0;
         wave_out <= MIDSCALE;
      end else begin
         state    <= state_nxt;
         level    <= level_nxt;
         wave_out <= {~prod[2*m-1], prod[2*m-2:m]};
      end
   end

   assign env_level = level;
   assign env_state = state;
   assign active    = (state != IDLE);

endmodule

// File: tb/tb_envelope.sv
// Bench for envelope: scaling vector table with a wave_out scoreboard, plus hand-written ADSR sequences.
module tb_envelope;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_tick;
   logic        gate;
   logic [11:0] wave_in;
   logic [7:0]  attack_rate, decay_rate, release_rate;
   logic [11:0] sustain_level;
   logic [11:0] wave_out, env_level;
   logic [2:0]  env_state;
   logic        active;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] lvl;
      logic [11:0] win;
      logic [11:0] expv;
   } vec_t;

   vec_t        vec[15];
   logic [11:0] sb[$];

   envelope #(.m(12), .r(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_tick   (sample_tick),
      .gate          (gate),
      .wave_in       (wave_in),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .sustain_level (sustain_level),
      .release_rate  (release_rate),
      .wave_out      (wave_out),
      .env_level     (env_level),
      .env_state     (env_state),
      .active        (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   // One quiet clk, then a single-cycle tick; returns just after the tick edge.
   task automatic tick();
      clk_step();
      sample_tick = 1'b1;
      clk_step();
      sample_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_env(input string nm, input int lvl, input int st);
      chk({nm, ".level"}, int'(env_level), lvl);
      chk({nm, ".state"}, int'(env_state), st);
      chk({nm, ".active"}, int'(active), (st != 0) ? 1 : 0);
   endtask

   // Applies every table vector for the held level; wave_out must lag wave_in by exactly one clk.
   task automatic scale_phase(input logic [11:0] lvl);
      logic        have_prev;
      logic [11:0] prev;
      logic [11:0] expv;
      have_prev = 1'b0;
      prev      = '0;
      chk("scale.level_precond", int'(env_level), int'(lvl));
      for (int i = 0; i < 15; i++) begin
         if (vec[i].lvl == lvl) begin
            wave_in = vec[i].win;
            sb.push_back(vec[i].expv);
            #1;
            if (have_prev) chk("scale.latency_hold", int'(wave_out), int'(prev));
            clk_step();
            expv = sb.pop_front();
            chk($sformatf("scale.l%0d_w%0d", lvl, vec[i].win), int'(wave_out), int'(expv));
            prev      = expv;
            have_prev = 1'b1;
         end
      end
   endtask

   initial begin
      vec[0]  = '{12'd4095, 12'd4095, 12'd4094};
      vec[1]  = '{12'd4095, 12'd0,    12'd0};
      vec[2]  = '{12'd4095, 12'd2048, 12'd2048};
      vec[3]  = '{12'd4095, 12'd1,    12'd1};
      vec[4]  = '{12'd4095, 12'd2047, 12'd2047};
      vec[5]  = '{12'd4095, 12'd2049, 12'd2048};
      vec[6]  = '{12'd2048, 12'd4095, 12'd3071};
      vec[7]  = '{12'd2048, 12'd0,    12'd1024};
      vec[8]  = '{12'd2048, 12'd1,    12'd1024};
      vec[9]  = '{12'd2048, 12'd2049, 12'd2048};
      vec[10] = '{12'd2048, 12'd2048, 12'd2048};
      vec[11] = '{12'd0,    12'd4095, 12'd2048};
      vec[12] = '{12'd0,    12'd0,    12'd2048};
      vec[13] = '{12'd0,    12'd1234, 12'd2048};
      vec[14] = '{12'd0,    12'd3000, 12'd2048};

      rst_n         = 1'b0;
      gate          = 1'b1;
      sample_tick   = 1'b0;
      wave_in       = 12'd4095;
      attack_rate   = 8'd255;
      decay_rate    = 8'd100;
      sustain_level = 12'd2048;
      release_rate  = 8'd64;

      // Reset held with gate high and a toggling tick.
      for (int i = 0; i < 4; i++) begin
         clk_step();
         sample_tick = ~sample_tick;
      end
      sample_tick = 1'b0;
      chk("reset.wave_out", int'(wave_out), 2048);
      chk_env("reset", 0, 0);

      // Gate high at deassert starts ATTACK on the first edge, level still 0.
      rst_n = 1'b1;
      clk_step();
      chk_env("deassert", 0, 1);
      scale_phase(12'd0);

      // Attack: 16 ticks to 4080, 17th saturates and enters DECAY.
      ticks(16);
      chk_env("attack16", 4080, 1);
      tick();
      chk_env("attack17", 4095, 2);
      scale_phase(12'd4095);

      // Decay: 20 ticks to 2095, 21st lands on sustain.
      ticks(20);
      chk_env("decay20", 2095, 2);
      tick();
      chk_env("decay21", 2048, 3);
      scale_phase(12'd2048);

      // Sustain tracking; wave_out follows env_level one clk later.
      wave_in = 12'd4095;
      clk_step();
      chk("sus.wave_pre", int'(wave_out), 3071);
      sustain_level = 12'd1000;
      tick();
      chk_env("sus_lower", 1000, 3);
      chk("sus.wave_old_level", int'(wave_out), 3071);
      clk_step();
      chk("sus.wave_new_level", int'(wave_out), 2547);
      sustain_level = 12'd2048;
      tick();
      chk_env("sus_raise", 2048, 3);

      // Gate fall on a tick edge: RELEASE wins, level unchanged.
      clk_step();
      gate        = 1'b0;
      sample_tick = 1'b1;
      clk_step();
      sample_tick = 1'b0;
      chk_env("gate_fall_tick", 2048, 4);
      ticks(31);
      chk_env("release31", 64, 4);
      tick();
      chk_env("release32", 0, 0);

      // Release mid-attack, then retrigger from the current level.
      gate = 1'b1;
      clk_step();
      chk_env("retrig_start", 0, 1);
      ticks(5);
      chk_env("mid_attack5", 1275, 1);
      gate = 1'b0;
      clk_step();
      chk_env("mid_release", 1275, 4);
      tick();
      chk_env("mid_release_tick", 1211, 4);
      gate = 1'b1;
      clk_step();
      chk_env("retrig", 1211, 1);
      tick();
      chk_env("retrig_tick", 1466, 1);

      // Zero attack rate holds level and state.
      attack_rate = 8'd0;
      ticks(3);
      chk_env("attack_zero", 1466, 1);
      attack_rate = 8'd255;

      // Sustain at full scale: DECAY exits on its first tick.
      ticks(10);
      chk_env("attack_to4016", 4016, 1);
      tick();
      chk_env("attack_sat", 4095, 2);
      sustain_level = 12'd4095;
      tick();
      chk_env("sustain_full", 4095, 3);
      wave_in = 12'd0;
      clk_step();
      chk("sustain_full.wave", int'(wave_out), 0);

      // Reset mid-SUSTAIN acts without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk_env("reset_mid", 0, 0);
      chk("reset_mid.wave_out", int'(wave_out), 2048);
      gate = 1'b0;
      clk_step();
      rst_n = 1'b1;
      clk_step();
      chk_env("post_reset_gate_low", 0, 0);
      gate = 1'b1;
      clk_step();
      chk_env("post_reset_gate_high", 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
